// File: rtl/ysyx_23060025_bus_arbiter_pkg.sv
// rtl/ysyx_23060025_bus_arbiter_pkg.sv - shared arbiter state encodings, grant ids and defaults
package ysyx_23060025_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_GNT_INST = 2'd1,
    ARB_GNT_DATA = 2'd2
  } arb_state_e;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  localparam int ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/ysyx_23060025_bus_arbiter_arb_pick.sv
// rtl/ysyx_23060025_bus_arbiter_arb_pick.sv - grant selection; YSYX_23060025_ARB_RR_EN selects round-robin
module ysyx_23060025_arb_pick
  import ysyx_23060025_bus_arbiter_pkg::*;
(
  input  logic inst_req,
  input  logic data_req,
  input  logic last_grant,
  output logic grant_inst,
  output logic grant_data
);

`ifdef YSYX_23060025_ARB_RR_EN
  // On a tie, whoever was not served last goes next.
  assign grant_data = data_req & (~inst_req | (last_grant == GRANT_INST));
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign grant_data = data_req;
`endif
  assign grant_inst = inst_req & ~grant_data;

endmodule

// File: rtl/ysyx_23060025_bus_arbiter.sv
// rtl/ysyx_23060025_bus_arbiter.sv - two-requester memory bus arbiter; YSYX_23060025_ARB_RR_EN enables round-robin
module ysyx_23060025_bus_arbiter
  import ysyx_23060025_bus_arbiter_pkg::*;
#(
  parameter int ADDR_LEN       = 32,
  parameter int DATA_LEN       = 32,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic                clock,
  input  logic                rstn,
  input  logic [ADDR_LEN-1:0] inst_paddr_i,
  input  logic                inst_psel_i,
  input  logic [7:0]          inst_plen_i,
  input  logic [2:0]          inst_psize_i,
  output logic                inst_pvalid_o,
  output logic                inst_plast_o,
  output logic [DATA_LEN-1:0] inst_prdata_o,
  input  logic [ADDR_LEN-1:0] data_paddr_i,
  input  logic                data_psel_i,
  input  logic                data_pwrite_i,
  input  logic [2:0]          data_psize_i,
  input  logic [DATA_LEN-1:0] data_pwdata_i,
  input  logic [3:0]          data_pwstrb_i,
  output logic                data_pvalid_o,
  output logic [DATA_LEN-1:0] data_prdata_o,
  output logic [ADDR_LEN-1:0] out_paddr,
  output logic                out_psel,
  output logic                out_pwrite,
  output logic [7:0]          out_plen,
  output logic [2:0]          out_psize,
  output logic [DATA_LEN-1:0] out_pwdata,
  output logic [3:0]          out_pwstrb,
  input  logic                out_pvalid,
  input  logic                out_plast,
  input  logic [DATA_LEN-1:0] out_prdata,
  output logic                timeout_o
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  arb_state_e state_q, state_d;
  logic       grant_inst, grant_data;
  logic       last_grant;
  logic [7:0] to_cnt;

  ysyx_23060025_arb_pick u_pick (
    .inst_req   (inst_psel_i),
    .data_req   (data_psel_i),
    .last_grant (last_grant),
    .grant_inst (grant_inst),
    .grant_data (grant_data)
  );

  always_comb begin
    state_d       = state_q;
    inst_pvalid_o = 1'b0;
    inst_plast_o  = 1'b0;
    data_pvalid_o = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (grant_data)      state_d = ARB_GNT_DATA;
        else if (grant_inst) state_d = ARB_GNT_INST;
      end
      ARB_GNT_INST: begin
        inst_pvalid_o = out_pvalid;
        inst_plast_o  = out_plast;
        if (out_pvalid && out_plast) state_d = ARB_IDLE;
      end
      ARB_GNT_DATA: begin
        data_pvalid_o = out_pvalid;
        if (out_pvalid) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign inst_prdata_o = out_prdata;
  assign data_prdata_o = out_prdata;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ARB_IDLE;
      out_paddr  <= '0;
      out_psel   <= 1'b0;
      out_pwrite <= 1'b0;
      out_plen   <= '0;
      out_psize  <= '0;
      out_pwdata <= '0;
      out_pwstrb <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ARB_IDLE && state_d == ARB_GNT_DATA) begin
        out_paddr  <= data_paddr_i;
        out_psel   <= 1'b1;
        out_pwrite <= data_pwrite_i;
        out_plen   <= '0;
        out_psize  <= data_psize_i;
        out_pwdata <= data_pwdata_i;
        out_pwstrb <= data_pwstrb_i;
      end else if (state_q == ARB_IDLE && state_d == ARB_GNT_INST) begin
        out_paddr  <= inst_paddr_i;
        out_psel   <= 1'b1;
        out_pwrite <= 1'b0;
        out_plen   <= inst_plen_i;
        out_psize  <= inst_psize_i;
        out_pwdata <= '0;
        out_pwstrb <= '0;
      end else if (state_q != ARB_IDLE && state_d == ARB_IDLE) begin
        out_psel <= 1'b0;
      end
    end
  end

`ifdef YSYX_23060025_ARB_RR_EN
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn)
      last_grant <= GRANT_INST;
    else if (state_q == ARB_IDLE && state_d == ARB_GNT_DATA)
      last_grant <= GRANT_DATA;
    else if (state_q == ARB_IDLE && state_d == ARB_GNT_INST)
      last_grant <= GRANT_INST;
  end
`else
  assign last_grant = GRANT_INST;
`endif

  // Idle cycles restart the count so each grant is timed on its own.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      to_cnt    <= '0;
      timeout_o <= 1'b0;
    end else if (state_q == ARB_IDLE || out_pvalid) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_LIM) begin
      to_cnt <= to_cnt + 8'd1;
      if (to_cnt == TO_LIM - 8'd1) timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_23060025_bus_arbiter.sv
// tb/tb_ysyx_23060025_bus_arbiter.sv - directed table-driven bench for the bus arbiter
module tb_ysyx_23060025_bus_arbiter;

  logic        clock = 1'b0;
  logic        rstn;
  logic [31:0] inst_paddr_i, data_paddr_i, data_pwdata_i, out_prdata;
  logic        inst_psel_i, data_psel_i, data_pwrite_i, out_pvalid, out_plast;
  logic [7:0]  inst_plen_i;
  logic [2:0]  inst_psize_i, data_psize_i;
  logic [3:0]  data_pwstrb_i;
  logic        inst_pvalid_o, inst_plast_o, data_pvalid_o;
  logic [31:0] inst_prdata_o, data_prdata_o, out_paddr, out_pwdata;
  logic        out_psel, out_pwrite, timeout_o;
  logic [7:0]  out_plen;
  logic [2:0]  out_psize;
  logic [3:0]  out_pwstrb;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  ysyx_23060025_bus_arbiter dut (
    .clock(clock), .rstn(rstn),
    .inst_paddr_i(inst_paddr_i), .inst_psel_i(inst_psel_i), .inst_plen_i(inst_plen_i),
    .inst_psize_i(inst_psize_i), .inst_pvalid_o(inst_pvalid_o), .inst_plast_o(inst_plast_o),
    .inst_prdata_o(inst_prdata_o),
    .data_paddr_i(data_paddr_i), .data_psel_i(data_psel_i), .data_pwrite_i(data_pwrite_i),
    .data_psize_i(data_psize_i), .data_pwdata_i(data_pwdata_i), .data_pwstrb_i(data_pwstrb_i),
    .data_pvalid_o(data_pvalid_o), .data_prdata_o(data_prdata_o),
    .out_paddr(out_paddr), .out_psel(out_psel), .out_pwrite(out_pwrite), .out_plen(out_plen),
    .out_psize(out_psize), .out_pwdata(out_pwdata), .out_pwstrb(out_pwstrb),
    .out_pvalid(out_pvalid), .out_plast(out_plast), .out_prdata(out_prdata),
    .timeout_o(timeout_o)
  );

  typedef struct {
    logic        is_data;
    logic [31:0] addr;
    logic [7:0]  plen;
    logic [2:0]  size;
    logic        pwrite;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rbase;
    int          beats;
    logic [7:0]  exp_plen;
    logic        exp_pwrite;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    inst_paddr_i = '0; inst_psel_i = 0; inst_plen_i = '0; inst_psize_i = '0;
    data_paddr_i = '0; data_psel_i = 0; data_pwrite_i = 0; data_psize_i = '0;
    data_pwdata_i = '0; data_pwstrb_i = '0;
    out_pvalid = 0; out_plast = 0; out_prdata = '0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h8000_0010, 8'd9, 3'd2, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1, 8'd0, 1'b1, 4'hF, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h8000_0020, 8'd5, 3'd1, 1'b0, 32'h1234_5678, 4'h3, 32'hCAFE_0001, 1, 8'd0, 1'b0, 4'h3, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h3000_0000, 8'd3, 3'd2, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0000_0011, 4, 8'd3, 1'b0, 4'h0, 32'h0};
    vecs[3] = '{1'b0, 32'h3000_0040, 8'd0, 3'd2, 1'b1, 32'hAAAA_5555, 4'hC, 32'h0000_00A0, 1, 8'd0, 1'b0, 4'h0, 32'h0};

    clear_inputs();
    rstn = 0;
    tick(); tick();
    check("rst_out_psel", out_psel, 0);
    check("rst_out_paddr", out_paddr, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_valids", {inst_pvalid_o, inst_plast_o, data_pvalid_o}, 0);
    rstn = 1;
    tick();

    for (int v = 0; v < 4; v++) begin
      // Data-side attributes are driven even for inst vectors to prove the inst grant masks them.
      data_pwrite_i = vecs[v].pwrite; data_pwdata_i = vecs[v].wdata; data_pwstrb_i = vecs[v].strb;
      data_psize_i = vecs[v].size;
      if (vecs[v].is_data) begin
        data_paddr_i = vecs[v].addr; data_psel_i = 1;
      end else begin
        inst_paddr_i = vecs[v].addr; inst_plen_i = vecs[v].plen; inst_psize_i = vecs[v].size;
        inst_psel_i = 1;
      end
      check($sformatf("v%0d_psel_pre", v), out_psel, 0);
      tick();
      check($sformatf("v%0d_psel", v), out_psel, 1);
      check($sformatf("v%0d_addr", v), out_paddr, vecs[v].addr);
      check($sformatf("v%0d_plen", v), out_plen, vecs[v].exp_plen);
      check($sformatf("v%0d_pwrite", v), out_pwrite, vecs[v].exp_pwrite);
      check($sformatf("v%0d_strb", v), out_pwstrb, vecs[v].exp_strb);
      check($sformatf("v%0d_size", v), out_psize, vecs[v].size);
      check($sformatf("v%0d_wdata", v), out_pwdata, vecs[v].exp_wdata);
      tick();
      check($sformatf("v%0d_wait_valid", v), {inst_pvalid_o, data_pvalid_o}, 0);
      for (int b = 0; b < vecs[v].beats; b++) begin
        out_pvalid = 1;
        out_prdata = vecs[v].rbase + 32'(b) * 32'h11;
        out_plast  = (b == vecs[v].beats - 1);
        #1;
        if (vecs[v].is_data) begin
          check($sformatf("v%0d_b%0d_dvalid", v, b), {data_pvalid_o, inst_pvalid_o}, 2'b10);
          check($sformatf("v%0d_b%0d_ddata", v, b), data_prdata_o, vecs[v].rbase + 32'(b) * 32'h11);
        end else begin
          check($sformatf("v%0d_b%0d_ivalid", v, b), {inst_pvalid_o, data_pvalid_o}, 2'b10);
          check($sformatf("v%0d_b%0d_ilast", v, b), inst_plast_o, (b == vecs[v].beats - 1));
          check($sformatf("v%0d_b%0d_idata", v, b), inst_prdata_o, vecs[v].rbase + 32'(b) * 32'h11);
        end
        tick();
        if (b == vecs[v].beats - 1) begin
          inst_psel_i = 0; data_psel_i = 0;
        end
        check($sformatf("v%0d_b%0d_psel", v, b), out_psel, (b != vecs[v].beats - 1));
        out_pvalid = 0; out_plast = 0;
      end
      tick();
      clear_inputs();
    end

    // Simultaneous requests: data wins, inst follows after one bubble.
    inst_paddr_i = 32'h3000_0100; inst_plen_i = 8'd0; inst_psel_i = 1;
    data_paddr_i = 32'h8000_0100; data_pwrite_i = 1; data_pwdata_i = 32'h5A5A_5A5A;
    data_pwstrb_i = 4'h1; data_psel_i = 1;
    tick();
    check("sim_first_addr", out_paddr, 32'h8000_0100);
    check("sim_first_pwrite", out_pwrite, 1);
    out_pvalid = 1; #1;
    check("sim_first_valids", {data_pvalid_o, inst_pvalid_o}, 2'b10);
    tick();
    out_pvalid = 0; data_psel_i = 0;
    check("sim_bubble_psel", out_psel, 0);
    tick();
    check("sim_second_psel", out_psel, 1);
    check("sim_second_addr", out_paddr, 32'h3000_0100);
    check("sim_second_pwrite", out_pwrite, 0);
    out_pvalid = 1; out_plast = 1; out_prdata = 32'h0BAD_F00D; #1;
    check("sim_second_valids", {inst_pvalid_o, inst_plast_o, data_pvalid_o}, 3'b110);
    tick();
    clear_inputs();
    check("sim_done_psel", out_psel, 0);
    tick();

    // Stray response while idle reaches nobody and starts nothing.
    out_pvalid = 1; out_plast = 1; out_prdata = 32'h7777_7777; #1;
    check("stray_valids", {inst_pvalid_o, inst_plast_o, data_pvalid_o}, 0);
    tick(); tick();
    check("stray_psel", out_psel, 0);
    clear_inputs();
    tick();

    // Timeout: grant held with no response.
    data_paddr_i = 32'h8000_0200; data_psel_i = 1;
    tick();
    check("to_grant", out_psel, 1);
    for (int i = 0; i < 254; i++) tick();
    check("to_before", timeout_o, 0);
    tick();
    check("to_rise", timeout_o, 1);
    for (int i = 0; i < 5; i++) tick();
    check("to_sticky", timeout_o, 1);
    check("to_still_granted", out_psel, 1);
    out_pvalid = 1; #1;
    check("to_complete_valid", data_pvalid_o, 1);
    tick();
    clear_inputs();
    check("to_complete_psel", out_psel, 0);
    check("to_after", timeout_o, 1);
    tick();

    // Asynchronous reset in the middle of a burst.
    inst_paddr_i = 32'h3000_0200; inst_plen_i = 8'd3; inst_psel_i = 1;
    tick();
    check("rr_grant", out_psel, 1);
    out_pvalid = 1; out_prdata = 32'h11; #1;
    check("rr_beat1", inst_pvalid_o, 1);
    tick();
    out_prdata = 32'h22;
    #2;
    rstn = 0;
    #1;
    check("rr_psel", out_psel, 0);
    check("rr_timeout", timeout_o, 0);
    check("rr_valid_gated", {inst_pvalid_o, inst_plast_o, data_pvalid_o}, 0);
    tick();
    clear_inputs();
    rstn = 1;
    tick();
    data_paddr_i = 32'h8000_0300; data_psel_i = 1; data_pwstrb_i = 4'h6;
    tick();
    check("rr_new_psel", out_psel, 1);
    check("rr_new_addr", out_paddr, 32'h8000_0300);
    check("rr_new_strb", out_pwstrb, 4'h6);
    out_pvalid = 1; #1;
    check("rr_new_valid", data_pvalid_o, 1);
    tick();
    clear_inputs();
    check("rr_new_done", out_psel, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
